ir_sense_seq: RTL and testbench
===============================

Name: ir_sense_seq

Overview:
- Upstream stage of the IR error computation. Owns the IR emitter enable and the A2D request/complete handshake.
- Periodically lights the IR LEDs, waits for them to settle, then converts eight reflectance channels in fixed order.
- Presents IR_R0..IR_R3 and IR_L0..IR_L3 as held 12-bit registers, with a one-cycle IR_vld strobe per complete sweep.
- IR_vld feeds directly into the IR_vld input of the error computation block.

Parameters:
- PERIOD_W, 18: width of the free-running sweep period counter; the sweep period is 2^PERIOD_W cycles.
- SETTLE_CYC, 4096: number of cycles IR_en is high before the first conversion; legal range 1..65535.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- strt_cnv  output  1  one-cycle conversion request to the A2D interface
- chnnl  output  3  A2D channel for the current request
- cnv_cmplt  input  1  one-cycle pulse from the A2D interface; res is valid in that cycle
- res  input  12  A2D conversion result
- IR_en  output  1  IR emitter enable
- IR_R0, IR_R1, IR_R2, IR_R3  output  12 each  right sensor readings, inside out
- IR_L0, IR_L1, IR_L2, IR_L3  output  12 each  left sensor readings, inside out
- IR_vld  output  1  one-cycle strobe; all eight readings are updated and stable

Behaviour:
- Reset: synchronous, sampled on the clk rising edge with rst_n low; it is the only reset.
  - All outputs go to 0: strt_cnv, chnnl, IR_en, IR_vld, and all eight IR registers.
  - Period counter, settle counter and channel index clear to 0; FSM goes to IDLE.
  - Reset mid-sweep aborts the sweep with no IR_vld and clears partially captured readings.
- Period counter:
  - Free-running, PERIOD_W bits, increments every cycle and wraps.
  - A "tick" occurs when it is all-ones.
  - Ticks outside IDLE are ignored; the counter never stalls.
- FSM states:
  - IDLE: IR_en=0. On tick, go to SETTLE and clear the settle counter.
  - SETTLE: IR_en=1; the settle counter increments each cycle. When it equals SETTLE_CYC-1, go to CONV.
  - CONV: strt_cnv=1 for exactly this one cycle; chnnl = current index. Always go to WAIT next cycle.
  - WAIT: hold chnnl; IR_en stays 1.
    - On cnv_cmplt, capture res into the register mapped by the index.
    - If index==7, go to DONE; otherwise increment the index and go to CONV.
  - DONE: IR_vld=1 for this single cycle, IR_en=0, index cleared. Go to IDLE.
- IR_en is high in SETTLE, CONV and WAIT only.
- Channel map:
  - 0=R0, 1=L0, 2=R1, 3=L1, 4=R2, 5=L2, 6=R3, 7=L3.
  - chnnl drives this index directly.
- Capture rule:
  - The register takes res unmodified, on the clock edge where cnv_cmplt is high in WAIT.
  - Registers hold between sweeps and update only on capture.
  - Each register changes at most once per sweep.
- cnv_cmplt outside WAIT (IDLE, SETTLE, CONV, DONE) is ignored: no capture, no state change.
- No timeout in WAIT: the FSM waits indefinitely for cnv_cmplt, and ticks during the wait are dropped.
- Latency:
  - Tick to IR_en high: 1 cycle.
  - IR_en high to first strt_cnv: SETTLE_CYC cycles.
  - Last cnv_cmplt to IR_vld: 1 cycle; registers are already updated in the IR_vld cycle.
- Throughput:
  - At most one sweep per period.
  - The design requires a sweep to complete within 2^PERIOD_W cycles; if it overruns, the next tick is skipped, not queued.

Decomposition:
- Package ir_sense_pkg holds:
  - the FSM state enum (IDLE, SETTLE, CONV, WAIT, DONE);
  - NUM_IR_CHNL=8;
  - channel index localparams CH_R0..CH_L3.
- One sub-module, ir_sense_timer, holds the period counter and settle counter.
  - It outputs tick and settle_done; its inputs are clk, rst_n and settle_clr.
- The FSM, channel index and capture registers stay in ir_sense_seq.

Test Plan:
- Reset and first sweep: PERIOD_W=10, SETTLE_CYC=16, rst_n released at cycle 0 → IR_en rises at cycle 1024; strt_cnv with chnnl=0 at cycle 1040.
- Full sweep: responder returns cnv_cmplt 5 cycles after each strt_cnv, with res = 12'h100+chnnl → IR_vld pulses exactly once, 1 cycle after the 8th cnv_cmplt.
  - Readings: IR_R0=12'h100, IR_L0=12'h101, IR_R1=12'h102, …, IR_L3=12'h107.
  - IR_en is 0 in the same cycle as IR_vld.
- Spurious complete: cnv_cmplt with res=12'hABC pulsed during IDLE and SETTLE → no register changes, no state change, no extra strt_cnv.
- Stalled A2D: responder withholds cnv_cmplt on channel 3 for 2000 cycles (PERIOD_W=10) → FSM stays in WAIT with chnnl=3 and IR_en=1; the tick is dropped.
  - After completion, exactly one IR_vld follows; the next sweep starts on the following tick.
- Reset mid-sweep: rst_n low for 1 cycle after channel 4 is captured → all outputs 0 next cycle, no IR_vld.
  - The next sweep starts 1024 cycles after reset release.
- Back-to-back sweeps: two consecutive periods with changed res values → IR_vld spacing is exactly 1024 cycles; registers hold between strobes.

Source files
------------

// File: rtl/ir_sense_pkg.sv
// Shared constants for the IR reflectance sensing sequencer: FSM encoding and channel map.
package ir_sense_pkg;

    localparam int unsigned NUM_IR_CHNL = 8;

    typedef logic [2:0] state_t;

    localparam state_t IDLE   = 3'd0;
    localparam state_t SETTLE = 3'd1;
    localparam state_t CONV   = 3'd2;
    localparam state_t WAIT   = 3'd3;
    localparam state_t DONE   = 3'd4;

    // Channel order interleaves right and left, inside out.
    localparam logic [2:0] CH_R0 = 3'd0;
    localparam logic [2:0] CH_L0 = 3'd1;
    localparam logic [2:0] CH_R1 = 3'd2;
    localparam logic [2:0] CH_L1 = 3'd3;
    localparam logic [2:0] CH_R2 = 3'd4;
    localparam logic [2:0] CH_L2 = 3'd5;
    localparam logic [2:0] CH_R3 = 3'd6;
    localparam logic [2:0] CH_L3 = 3'd7;

endpackage

// File: rtl/ir_sense_timer.sv
// Free-running sweep period counter and emitter settle counter for ir_sense_seq.
module ir_sense_timer #(
    parameter int unsigned PERIOD_W   = 18,
    parameter int unsigned SETTLE_CYC = 4096
) (
    input  logic clk,
    input  logic rst_n,
    input  logic settle_clr,
    output logic tick,
    output logic settle_done
);

    logic [PERIOD_W-1:0] period_q;
    logic [15:0]         settle_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            period_q <= '0;
            settle_q <= '0;
        end else begin
            period_q <= period_q + 1'b1;
            settle_q <= settle_clr ? 16'd0 : settle_q + 16'd1;
        end
    end

    // Settle count is only meaningful while the sequencer sits in SETTLE.
    assign tick        = &period_q;
    assign settle_done = (settle_q == 16'(SETTLE_CYC - 1));

endmodule

// File: rtl/ir_sense_seq.sv
// IR sense sequencer: lights the emitters, lets them settle, then converts eight channels.
module ir_sense_seq
    import ir_sense_pkg::*;
#(
    parameter int unsigned PERIOD_W   = 18,
    parameter int unsigned SETTLE_CYC = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        strt_cnv,
    output logic [2:0]  chnnl,
    input  logic        cnv_cmplt,
    input  logic [11:0] res,
    output logic        IR_en,
    output logic [11:0] IR_R0,
    output logic [11:0] IR_R1,
    output logic [11:0] IR_R2,
    output logic [11:0] IR_R3,
    output logic [11:0] IR_L0,
    output logic [11:0] IR_L1,
    output logic [11:0] IR_L2,
    output logic [11:0] IR_L3,
    output logic        IR_vld
);

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [11:0] ir_q [NUM_IR_CHNL];
    logic        tick, settle_done, settle_clr;

    ir_sense_timer #(
        .PERIOD_W   (PERIOD_W),
        .SETTLE_CYC (SETTLE_CYC)
    ) u_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .settle_clr  (settle_clr),
        .tick        (tick),
        .settle_done (settle_done)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        settle_clr = 1'b0;
        case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d    = SETTLE;
                    settle_clr = 1'b1;
                end
            end
            SETTLE: if (settle_done) state_d = CONV;
            CONV:   state_d = WAIT;
            WAIT: begin
                if (cnv_cmplt) begin
                    if (idx_q == CH_L3) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = CONV;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                idx_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            for (int i = 0; i < NUM_IR_CHNL; i++) ir_q[i] <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (state_q == WAIT && cnv_cmplt) ir_q[idx_q] <= res;
        end
    end

    assign strt_cnv = (state_q == CONV);
    assign chnnl    = idx_q;
    assign IR_en    = (state_q == SETTLE) || (state_q == CONV) || (state_q == WAIT);
    assign IR_vld   = (state_q == DONE);

    assign IR_R0 = ir_q[CH_R0];
    assign IR_L0 = ir_q[CH_L0];
    assign IR_R1 = ir_q[CH_R1];
    assign IR_L1 = ir_q[CH_L1];
    assign IR_R2 = ir_q[CH_R2];
    assign IR_L2 = ir_q[CH_L2];
    assign IR_R3 = ir_q[CH_R3];
    assign IR_L3 = ir_q[CH_L3];

endmodule

// File: tb/tb_ir_sense_seq.sv
// Bench for ir_sense_seq: sweep timing, channel order, capture, stall, spurious completes, reset.
module tb_ir_sense_seq;

    localparam int PW     = 10;
    localparam int SC     = 16;
    localparam int PERIOD = 1 << PW;

    logic        clk = 1'b0;
    logic        rst_n, strt_cnv, cnv_cmplt, IR_en, IR_vld;
    logic [2:0]  chnnl;
    logic [11:0] res;
    logic [11:0] IR_R0, IR_R1, IR_R2, IR_R3, IR_L0, IR_L1, IR_L2, IR_L3;
    logic [11:0] obs_reg [8];
    logic [11:0] exp_reg [8];

    int cyc;
    int total = 0;
    int bad   = 0;
    int idle_from;
    int v1, v2, v3, v4, vx, v5;

    ir_sense_seq #(
        .PERIOD_W   (PW),
        .SETTLE_CYC (SC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .strt_cnv  (strt_cnv),
        .chnnl     (chnnl),
        .cnv_cmplt (cnv_cmplt),
        .res       (res),
        .IR_en     (IR_en),
        .IR_R0     (IR_R0),
        .IR_R1     (IR_R1),
        .IR_R2     (IR_R2),
        .IR_R3     (IR_R3),
        .IR_L0     (IR_L0),
        .IR_L1     (IR_L1),
        .IR_L2     (IR_L2),
        .IR_L3     (IR_L3),
        .IR_vld    (IR_vld)
    );

    always #5 clk = ~clk;

    // Cycle index relative to the last reset edge; period counter value equals cyc mod PERIOD.
    always @(posedge clk) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Readings listed in conversion channel order.
    assign obs_reg[0] = IR_R0;
    assign obs_reg[1] = IR_L0;
    assign obs_reg[2] = IR_R1;
    assign obs_reg[3] = IR_L1;
    assign obs_reg[4] = IR_R2;
    assign obs_reg[5] = IR_L2;
    assign obs_reg[6] = IR_R3;
    assign obs_reg[7] = IR_L3;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic summary_and_finish();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    endtask

    function automatic int next_tick(input int from);
        return from + (PERIOD - 1 - (from % PERIOD));
    endfunction

    task automatic check_regs(input string tag);
        for (int i = 0; i < 8; i++) chk($sformatf("%s_reg%0d", tag, i), obs_reg[i], exp_reg[i]);
    endtask

    task automatic check_idle_outs(input string tag);
        chk({tag, "_strt"}, strt_cnv, 1'b0);
        chk({tag, "_en"}, IR_en, 1'b0);
        chk({tag, "_vld"}, IR_vld, 1'b0);
        chk({tag, "_chnnl"}, chnnl, 3'd0);
    endtask

    // One sweep with a responder; fixed_d>0 gives a fixed complete delay, else random 1..8.
    task automatic do_sweep(input int fixed_d, input int stall_ch, input int stall_len,
                            input int rst_ch, input bit spur, output int vld_cyc);
        int  exp_rise, d, stray;
        bit  got;
        exp_rise = next_tick(idle_from) + 1;
        vld_cyc  = -1;
        got      = 1'b0;
        stray    = 0;
        for (int n = 0; n < 2 * PERIOD + 10; n++) begin
            if (IR_en) begin
                got = 1'b1;
                break;
            end
            if (strt_cnv || IR_vld) stray++;
            if (spur && cyc == exp_rise - 100) begin
                cnv_cmplt = 1'b1;
                res       = 12'hABC;
            end else begin
                cnv_cmplt = 1'b0;
            end
            step();
        end
        cnv_cmplt = 1'b0;
        chk("rise_seen", got, 1'b1);
        if (!got) summary_and_finish();
        chk("rise_cyc", cyc, exp_rise);
        chk("idle_stray", stray, 0);
        check_regs("hold");

        got   = 1'b0;
        stray = 0;
        for (int n = 0; n < SC + 5; n++) begin
            if (strt_cnv) begin
                got = 1'b1;
                break;
            end
            if (!IR_en || IR_vld) stray++;
            if (spur && cyc == exp_rise + 5) begin
                cnv_cmplt = 1'b1;
                res       = 12'hABC;
            end else begin
                cnv_cmplt = 1'b0;
            end
            step();
        end
        cnv_cmplt = 1'b0;
        chk("strt_seen", got, 1'b1);
        if (!got) summary_and_finish();
        chk("first_strt_cyc", cyc, exp_rise + SC);
        chk("settle_stray", stray, 0);
        if (spur) check_regs("spur");

        for (int ch = 0; ch < 8; ch++) begin
            chk($sformatf("strt%0d", ch), strt_cnv, 1'b1);
            chk($sformatf("chnnl%0d", ch), chnnl, ch);
            chk($sformatf("en%0d", ch), IR_en, 1'b1);
            if (ch == stall_ch)  d = stall_len;
            else if (fixed_d > 0) d = fixed_d;
            else                  d = $urandom_range(1, 8);
            stray = 0;
            for (int k = 0; k < d; k++) begin
                step();
                if (strt_cnv || !IR_en || chnnl != 3'(ch) || IR_vld) stray++;
            end
            chk($sformatf("wait%0d_hold", ch), stray, 0);
            cnv_cmplt   = 1'b1;
            res         = 12'($urandom);
            exp_reg[ch] = res;
            step();
            cnv_cmplt = 1'b0;
            if (ch == rst_ch) begin
                rst_n = 1'b0;
                step();
                rst_n = 1'b1;
                check_idle_outs("rst");
                for (int i = 0; i < 8; i++) exp_reg[i] = '0;
                check_regs("rst");
                chk("rst_cyc", cyc, 0);
                idle_from = 0;
                return;
            end
            if (ch == 7) begin
                chk("vld_hi", IR_vld, 1'b1);
                chk("vld_en_lo", IR_en, 1'b0);
                chk("vld_strt_lo", strt_cnv, 1'b0);
                check_regs("vld");
                vld_cyc = cyc;
                step();
                chk("vld_one_cycle", IR_vld, 1'b0);
                idle_from = vld_cyc + 1;
            end else begin
                chk($sformatf("no_vld%0d", ch), IR_vld, 1'b0);
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        cnv_cmplt = 1'b0;
        res       = '0;
        for (int i = 0; i < 8; i++) exp_reg[i] = '0;
        repeat (3) step();
        check_idle_outs("reset");
        check_regs("reset");
        rst_n     = 1'b1;
        idle_from = 0;

        do_sweep(0, -1, 0, -1, 1'b1, v1);
        do_sweep(0, 3, 2000, -1, 1'b0, v2);
        do_sweep(5, -1, 0, -1, 1'b0, v3);
        do_sweep(5, -1, 0, -1, 1'b0, v4);
        chk("b2b_spacing", v4 - v3, PERIOD);
        do_sweep(0, -1, 0, 4, 1'b0, vx);
        do_sweep(0, -1, 0, -1, 1'b0, v5);

        summary_and_finish();
    end

endmodule
